// File: rtl/controlador_jogo_pkg.sv
// Shared definitions for the battleship game sequencer: phase encodings,
// switch mode codes and counter widths.
package jogo_pkg;

  localparam int VIDA_W   = 3;
  localparam int ACERTO_W = 3;

  // Game phase, also the encoding driven on the estado output
  typedef enum logic [1:0] {
    DESLIGADO  = 2'b00,
    PREPARACAO = 2'b01,
    ATAQUE     = 2'b10,
    FIM        = 2'b11
  } estado_t;

  // {ch7,ch6} switch codes
  localparam logic [1:0] MODO_OFF    = 2'b00;
  localparam logic [1:0] MODO_PREP   = 2'b01;
  localparam logic [1:0] MODO_ATAQUE = 2'b10;
  localparam logic [1:0] MODO_HOLD   = 2'b11;

endpackage

// File: rtl/controlador_jogo_if.sv
// Signal bundle between the button/switch front end, the game sequencer
// and the datapath enables/status it drives.
interface controlador_jogo_if;
  import jogo_pkg::*;

  logic [1:0]          modo;
  logic                confirmar;
  logic                tiro_valido;
  logic                tiro_acerto;
  logic                tiro_repetido;
  logic [1:0]          estado;
  logic                en_preparacao;
  logic                en_ataque;
  logic                ligar_matriz;
  logic [VIDA_W-1:0]   vida;
  logic [ACERTO_W-1:0] acertos;
  logic                vitoria;
  logic                derrota;

  // Front end / board side: drives switches and shot results
  modport master (
    output modo, confirmar, tiro_valido, tiro_acerto, tiro_repetido,
    input  estado, en_preparacao, en_ataque, ligar_matriz, vida, acertos,
           vitoria, derrota
  );

  // Sequencer side
  modport slave (
    input  modo, confirmar, tiro_valido, tiro_acerto, tiro_repetido,
    output estado, en_preparacao, en_ataque, ligar_matriz, vida, acertos,
           vitoria, derrota
  );
endinterface

// File: rtl/controlador_jogo_contador_piscar.sv
// End-of-game blink generator. Output is 0 while disabled; i_clr restarts
// the phase at 1, after which it toggles every PISCA_DIV enabled clocks.
module contador_piscar #(
  parameter int PISCA_DIV = 381
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_pisca
);
  localparam int CNT_W = (PISCA_DIV > 1) ? $clog2(PISCA_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_pisca;

  // Half-period counter and phase toggle on terminal count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_pisca <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_pisca <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_pisca <= 1'b1;
    end else if (r_cnt == CNT_W'(PISCA_DIV - 1)) begin
      r_cnt   <= '0;
      r_pisca <= ~r_pisca;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_pisca = r_pisca;
endmodule

// File: rtl/controlador_jogo.sv
// Battleship game sequencer: phase FSM, lives/hits counters and datapath
// enables. Optional feature macro CONTROLADOR_PISCA_FIM_EN makes the LED
// matrix blink during FIM; without it the matrix is dark in FIM.
module controlador_jogo
  import jogo_pkg::*;
#(
  parameter int VIDAS_INICIAIS = 7,
  parameter int ALVOS          = 5,
  parameter int PISCA_DIV      = 381
) (
  input  logic                clock,
  input  logic                reset_n,
  controlador_jogo_if.slave   bus
);
  localparam logic [ACERTO_W:0]   C_ALVOS = (ACERTO_W + 1)'(ALVOS);
  localparam logic [VIDA_W-1:0]   C_VIDAS = VIDA_W'(VIDAS_INICIAIS);

  estado_t             r_estado, w_estado_next;
  logic [VIDA_W-1:0]   r_vida, w_vida_next;
  logic [ACERTO_W-1:0] r_acertos, w_acertos_next;
  logic                r_mapa_ok, w_mapa_ok_next;
  logic                r_vitoria, w_vitoria_next;
  logic                r_derrota, w_derrota_next;
  logic                r_en_prep, w_en_prep_next;
  logic                r_en_ataque, w_en_ataque_next;
  logic                r_ligar_base, w_ligar_base_next;
  logic                w_pisca;

  logic                w_tiro;
  logic [ACERTO_W:0]   w_acertos_mais1;
  logic                w_vence;
  logic                w_perde;

  // A counted shot needs ATAQUE with modo 10 or 11; repeated cells never count
  assign w_tiro          = (r_estado == ATAQUE) && bus.modo[1] &&
                           bus.tiro_valido && !bus.tiro_repetido;
  assign w_acertos_mais1 = {1'b0, r_acertos} + (ACERTO_W + 1)'(1);
  assign w_vence         = w_tiro && bus.tiro_acerto && (w_acertos_mais1 == C_ALVOS);
  assign w_perde         = w_tiro && !bus.tiro_acerto && (r_vida == VIDA_W'(1));

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado     <= DESLIGADO;
      r_vida       <= '0;
      r_acertos    <= '0;
      r_mapa_ok    <= 1'b0;
      r_vitoria    <= 1'b0;
      r_derrota    <= 1'b0;
      r_en_prep    <= 1'b0;
      r_en_ataque  <= 1'b0;
      r_ligar_base <= 1'b0;
    end else begin
      r_estado     <= w_estado_next;
      r_vida       <= w_vida_next;
      r_acertos    <= w_acertos_next;
      r_mapa_ok    <= w_mapa_ok_next;
      r_vitoria    <= w_vitoria_next;
      r_derrota    <= w_derrota_next;
      r_en_prep    <= w_en_prep_next;
      r_en_ataque  <= w_en_ataque_next;
      r_ligar_base <= w_ligar_base_next;
    end
  end

  // Phase transitions; modo 00 overrides everything, modo 11 blocks mode-driven moves
  always_comb begin
    w_estado_next = r_estado;
    if (bus.modo == MODO_OFF) begin
      w_estado_next = DESLIGADO;
    end else begin
      case (r_estado)
        DESLIGADO:  if (bus.modo == MODO_PREP) w_estado_next = PREPARACAO;
        PREPARACAO: if (bus.modo == MODO_ATAQUE && r_mapa_ok) w_estado_next = ATAQUE;
        ATAQUE: begin
          if (bus.modo == MODO_PREP)   w_estado_next = PREPARACAO;
          else if (w_vence || w_perde) w_estado_next = FIM;
        end
        FIM:        if (bus.modo == MODO_PREP) w_estado_next = PREPARACAO;
        default:    w_estado_next = DESLIGADO;
      endcase
    end
  end

  // Next values of counters, flags and enables
  always_comb begin
    w_vida_next    = r_vida;
    w_acertos_next = r_acertos;
    w_mapa_ok_next = r_mapa_ok;
    w_vitoria_next = r_vitoria;
    w_derrota_next = r_derrota;
    if (bus.modo == MODO_OFF) begin
      w_mapa_ok_next = 1'b0;
      w_vitoria_next = 1'b0;
      w_derrota_next = 1'b0;
    end else begin
      case (r_estado)
        PREPARACAO: begin
          if (bus.confirmar) w_mapa_ok_next = 1'b1;
          if (w_estado_next == ATAQUE) begin
            w_vida_next    = C_VIDAS;
            w_acertos_next = '0;
          end
        end
        ATAQUE: begin
          if (bus.modo == MODO_PREP) begin
            w_mapa_ok_next = 1'b0;
          end else if (w_tiro) begin
            if (bus.tiro_acerto) begin
              if ({1'b0, r_acertos} < C_ALVOS) w_acertos_next = w_acertos_mais1[ACERTO_W-1:0];
            end else if (r_vida != '0) begin
              w_vida_next = r_vida - VIDA_W'(1);
            end
            if (w_vence) w_vitoria_next = 1'b1;
            if (w_perde) w_derrota_next = 1'b1;
          end
        end
        FIM: begin
          if (bus.modo == MODO_PREP) begin
            w_mapa_ok_next = 1'b0;
            w_vitoria_next = 1'b0;
            w_derrota_next = 1'b0;
          end
        end
        default: ;
      endcase
    end
    w_en_prep_next    = (w_estado_next == PREPARACAO);
    w_en_ataque_next  = (w_estado_next == ATAQUE);
    w_ligar_base_next = w_en_prep_next || w_en_ataque_next;
  end

`ifdef CONTROLADOR_PISCA_FIM_EN
  logic w_pisca_en;
  logic w_pisca_clr;
  assign w_pisca_en  = (w_estado_next == FIM);
  assign w_pisca_clr = (w_estado_next == FIM) && (r_estado != FIM);

  contador_piscar #(.PISCA_DIV(PISCA_DIV)) u_pisca (
    .clock   (clock),
    .reset_n (reset_n),
    .i_en    (w_pisca_en),
    .i_clr   (w_pisca_clr),
    .o_pisca (w_pisca)
  );
`else
  assign w_pisca = 1'b0;
`endif

  // Both sources are flops and never high together
  assign bus.ligar_matriz  = r_ligar_base | w_pisca;
  assign bus.estado        = r_estado;
  assign bus.en_preparacao = r_en_prep;
  assign bus.en_ataque     = r_en_ataque;
  assign bus.vida          = r_vida;
  assign bus.acertos       = r_acertos;
  assign bus.vitoria       = r_vitoria;
  assign bus.derrota       = r_derrota;
endmodule

// File: tb/tb_controlador_jogo.sv
// Directed bench for controlador_jogo; blink expectations follow
// CONTROLADOR_PISCA_FIM_EN.
module tb_controlador_jogo;
`ifdef CONTROLADOR_PISCA_FIM_EN
  localparam int PISCA = 1;
`else
  localparam int PISCA = 0;
`endif

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  controlador_jogo_if bus ();

  controlador_jogo #(.VIDAS_INICIAIS(7), .ALVOS(5), .PISCA_DIV(381)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verifica(input string tag, input int obs, input int esp);
    n_checks++;
    if (obs != esp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tiro(input logic acerto, input logic repetido);
    bus.tiro_valido   = 1'b1;
    bus.tiro_acerto   = acerto;
    bus.tiro_repetido = repetido;
    tick();
    bus.tiro_valido   = 1'b0;
    bus.tiro_acerto   = 1'b0;
    bus.tiro_repetido = 1'b0;
  endtask

  task automatic vai_ataque();
    bus.modo = 2'b01; tick();
    bus.confirmar = 1'b1; tick(); bus.confirmar = 1'b0;
    bus.modo = 2'b10; tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    bus.modo = 2'b00;
    bus.confirmar = 1'b0;
    bus.tiro_valido = 1'b0;
    bus.tiro_acerto = 1'b0;
    bus.tiro_repetido = 1'b0;
    tick(); tick();
    verifica("rst_estado", int'(bus.estado), 0);
    verifica("rst_vida", int'(bus.vida), 0);
    verifica("rst_acertos", int'(bus.acertos), 0);
    verifica("rst_ligar", int'(bus.ligar_matriz), 0);
    verifica("rst_en", int'({bus.en_preparacao, bus.en_ataque}), 0);
    verifica("rst_vd", int'({bus.vitoria, bus.derrota}), 0);
    reset_n = 1'b1;

    // attack without a prepared map is refused
    bus.modo = 2'b10; tick(); tick();
    verifica("off_atq_estado", int'(bus.estado), 0);
    verifica("off_atq_ligar", int'(bus.ligar_matriz), 0);

    bus.modo = 2'b01; tick();
    verifica("prep_estado", int'(bus.estado), 1);
    verifica("prep_en", int'(bus.en_preparacao), 1);
    verifica("prep_ligar", int'(bus.ligar_matriz), 1);
    bus.modo = 2'b10; tick();
    verifica("prep_sem_mapa", int'(bus.estado), 1);
    tiro(1'b0, 1'b0);
    verifica("prep_tiro_ign", int'(bus.vida), 0);

    bus.modo = 2'b01;
    bus.confirmar = 1'b1; tick(); bus.confirmar = 1'b0;
    verifica("confirm_estado", int'(bus.estado), 1);
    bus.modo = 2'b10; tick();
    verifica("atq_estado", int'(bus.estado), 2);
    verifica("atq_vida", int'(bus.vida), 7);
    verifica("atq_acertos", int'(bus.acertos), 0);
    verifica("atq_en", int'({bus.en_preparacao, bus.en_ataque}), 1);

    tiro(1'b1, 1'b1);
    verifica("rep_acertos", int'(bus.acertos), 0);
    verifica("rep_vida", int'(bus.vida), 7);
    tiro(1'b0, 1'b0);
    verifica("erro_vida", int'(bus.vida), 6);
    tiro(1'b0, 1'b1);
    verifica("erro_rep_vida", int'(bus.vida), 6);
    bus.modo = 2'b11;
    tiro(1'b1, 1'b0);
    verifica("hold_acertos", int'(bus.acertos), 1);
    verifica("hold_estado", int'(bus.estado), 2);
    bus.modo = 2'b10;
    for (int k = 2; k <= 4; k++) begin
      tiro(1'b1, 1'b0);
      verifica($sformatf("hit%0d", k), int'(bus.acertos), k);
      verifica($sformatf("hit%0d_estado", k), int'(bus.estado), 2);
    end
    tiro(1'b1, 1'b0);
    verifica("win_acertos", int'(bus.acertos), 5);
    verifica("win_estado", int'(bus.estado), 3);
    verifica("win_vd", int'({bus.vitoria, bus.derrota}), 2);
    verifica("win_en_atq", int'(bus.en_ataque), 0);
    verifica("win_ligar", int'(bus.ligar_matriz), PISCA);
    tiro(1'b1, 1'b0);
    verifica("fim_frozen", int'(bus.acertos), 5);

    // FIM -> PREPARACAO clears map and result flags
    bus.modo = 2'b01; tick();
    verifica("fim_prep_estado", int'(bus.estado), 1);
    verifica("fim_prep_vit", int'(bus.vitoria), 0);
    bus.modo = 2'b10; tick();
    verifica("fim_prep_mapa0", int'(bus.estado), 1);

    vai_ataque();
    verifica("reload_vida", int'(bus.vida), 7);
    verifica("reload_acertos", int'(bus.acertos), 0);
    for (int k = 1; k <= 7; k++) begin
      tiro(1'b0, 1'b0);
      verifica($sformatf("miss%0d_vida", k), int'(bus.vida), 7 - k);
      if (k == 3) begin
        tiro(1'b0, 1'b1);
        verifica("miss_rep_vida", int'(bus.vida), 4);
      end
    end
    verifica("loss_estado", int'(bus.estado), 3);
    verifica("loss_vd", int'({bus.vitoria, bus.derrota}), 1);
    verifica("blink_entry", int'(bus.ligar_matriz), PISCA);
    for (int k = 1; k <= 380; k++) tick();
    verifica("blink_380", int'(bus.ligar_matriz), PISCA);
    tick();
    verifica("blink_381", int'(bus.ligar_matriz), 0);
    for (int k = 1; k <= 381; k++) tick();
    verifica("blink_762", int'(bus.ligar_matriz), PISCA);

    bus.modo = 2'b00; tick();
    verifica("off_estado", int'(bus.estado), 0);
    verifica("off_derrota", int'(bus.derrota), 0);
    verifica("off_vida_hold", int'(bus.vida), 0);
    verifica("off_ligar", int'(bus.ligar_matriz), 0);

    // ATAQUE -> PREPARACAO keeps counters but drops the map
    vai_ataque();
    tiro(1'b0, 1'b0);
    verifica("ret_vida_pre", int'(bus.vida), 6);
    bus.modo = 2'b01; tick();
    verifica("ret_estado", int'(bus.estado), 1);
    verifica("ret_vida", int'(bus.vida), 6);
    bus.modo = 2'b10; tick();
    verifica("ret_mapa0", int'(bus.estado), 1);

    // asynchronous abort mid-cycle
    vai_ataque();
    #2 reset_n = 1'b0;
    #1;
    verifica("async_estado", int'(bus.estado), 0);
    verifica("async_vida", int'(bus.vida), 0);
    verifica("async_en", int'(bus.en_ataque), 0);
    tick();
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
